// File: rtl/gray_stream_decoder_if.sv
// Valid/ready stream bundle between a Gray-code source, the decoder and its consumer.
// The master side drives codes in and takes decoded beats out. The slave side is the decoder.
interface gray_stream_decoder_if #(
    parameter int WIDTH     = 4,
    parameter int ERR_CNT_W = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_gray;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_bin;
    logic [1:0]           out_dir;
    logic                 out_step_err;
    logic [ERR_CNT_W-1:0] err_count;

    modport master (
        output in_valid, in_gray, out_ready,
        input  in_ready, out_valid, out_bin, out_dir, out_step_err, err_count
    );

    modport slave (
        input  in_valid, in_gray, out_ready,
        output in_ready, out_valid, out_bin, out_dir, out_step_err, err_count
    );
endinterface

// File: rtl/gray_stream_decoder.sv
// Registered Gray-to-binary decoder that classifies each accepted code against the previous one
// as up, down, hold or illegal jump, and keeps a saturating count of the illegal jumps.
module gray_stream_decoder #(
    parameter int WIDTH     = 4,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    gray_stream_decoder_if.slave bus
);
    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_TRACK = 1'b1
    } state_t;

    localparam logic [1:0]           DIR_HOLD = 2'b00;
    localparam logic [1:0]           DIR_UP   = 2'b01;
    localparam logic [1:0]           DIR_DOWN = 2'b10;
    localparam logic [WIDTH-1:0]     ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ERR_CNT_W-1:0] ERR_MAX  = {ERR_CNT_W{1'b1}};

    function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     prev_bin_q, prev_bin_d;
    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     out_bin_q, out_bin_d;
    logic [1:0]           out_dir_q, out_dir_d;
    logic                 out_step_err_q, out_step_err_d;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

    logic                 in_ready_s;
    logic                 accept_s;
    logic [WIDTH-1:0]     cur_bin_s;
    logic [WIDTH-1:0]     prev_inc_s;
    logic [WIDTH-1:0]     prev_dec_s;

    // Handshake, classification of the incoming code and next-state selection.
    always_comb begin
        in_ready_s     = rst_n && (!out_valid_q || bus.out_ready);
        accept_s       = bus.in_valid && in_ready_s;
        cur_bin_s      = gray_to_bin(bus.in_gray);
        prev_inc_s     = prev_bin_q + ONE;
        prev_dec_s     = prev_bin_q - ONE;

        state_d        = state_q;
        prev_bin_d     = prev_bin_q;
        out_valid_d    = out_valid_q;
        out_bin_d      = out_bin_q;
        out_dir_d      = out_dir_q;
        out_step_err_d = out_step_err_q;
        err_count_d    = err_count_q;

        if (accept_s) begin
            out_valid_d    = 1'b1;
            out_bin_d      = cur_bin_s;
            prev_bin_d     = cur_bin_s;
            state_d        = ST_TRACK;
            out_dir_d      = DIR_HOLD;
            out_step_err_d = 1'b0;
            // A clear coinciding with an accepted code makes that code a first code.
            if (clear) begin
                err_count_d = '0;
            end else begin
                case (state_q)
                    ST_EMPTY: begin
                        out_dir_d = DIR_HOLD;
                    end
                    ST_TRACK: begin
                        if (cur_bin_s == prev_inc_s) begin
                            out_dir_d = DIR_UP;
                        end else if (cur_bin_s == prev_dec_s) begin
                            out_dir_d = DIR_DOWN;
                        end else if (cur_bin_s == prev_bin_q) begin
                            out_dir_d = DIR_HOLD;
                        end else begin
                            out_step_err_d = 1'b1;
                            if (err_count_q != ERR_MAX) begin
                                err_count_d = err_count_q + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
                            end else begin
                                err_count_d = err_count_q;
                            end
                        end
                    end
                    default: begin
                        state_d = ST_EMPTY;
                    end
                endcase
            end
        end else begin
            if (bus.out_ready) begin
                out_valid_d = 1'b0;
            end else begin
                out_valid_d = out_valid_q;
            end
            // clear forgets history but leaves any pending beat in place.
            if (clear) begin
                state_d     = ST_EMPTY;
                err_count_d = '0;
            end else begin
                state_d     = state_q;
                err_count_d = err_count_q;
            end
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_EMPTY;
            prev_bin_q     <= '0;
            out_valid_q    <= 1'b0;
            out_bin_q      <= '0;
            out_dir_q      <= DIR_HOLD;
            out_step_err_q <= 1'b0;
            err_count_q    <= '0;
        end else begin
            state_q        <= state_d;
            prev_bin_q     <= prev_bin_d;
            out_valid_q    <= out_valid_d;
            out_bin_q      <= out_bin_d;
            out_dir_q      <= out_dir_d;
            out_step_err_q <= out_step_err_d;
            err_count_q    <= err_count_d;
        end
    end

    assign bus.in_ready     = in_ready_s;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_bin      = out_bin_q;
    assign bus.out_dir      = out_dir_q;
    assign bus.out_step_err = out_step_err_q;
    assign bus.err_count    = err_count_q;
endmodule

// File: tb/tb_gray_stream_decoder.sv
// Bench for gray_stream_decoder: a directed vector table, hand-written handshake/reset sequences,
// then random traffic checked against an arithmetic model of the step rules.
module tb_gray_stream_decoder;
    localparam int W  = 4;
    localparam int EW = 2;

    logic clk;
    logic rst_n;
    logic clear;

    gray_stream_decoder_if #(.WIDTH(W), .ERR_CNT_W(EW)) bus ();

    gray_stream_decoder #(.WIDTH(W), .ERR_CNT_W(EW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state.
    bit m_valid;
    int m_bin;
    int m_dir;
    bit m_err;
    int m_cnt;
    bit m_have_prev;
    int m_prev;

    typedef struct {
        bit       v;
        logic [3:0] g;
        bit       ordy;
        bit       clr;
        bit       e_valid;
        int       e_bin;
        int       e_dir;
        bit       e_err;
        int       e_cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [3:0] to_gray(input int b);
        logic [3:0] x;
        x = b[3:0];
        return x ^ (x >> 1);
    endfunction

    function automatic int from_gray(input logic [3:0] g);
        int acc;
        acc = 0;
        for (int s = 0; s < W; s++) acc = acc ^ int'(g >> s);
        return acc % 16;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs, check in_ready, clock it and advance the model.
    task automatic drive(input bit v, input logic [3:0] g, input bit ordy, input bit clr, input bit rn);
        bit acc;
        int cur;
        int diff;
        bus.in_valid  = v;
        bus.in_gray   = g;
        bus.out_ready = ordy;
        clear         = clr;
        rst_n         = rn;
        #1;
        chk("in_ready", int'(bus.in_ready), int'(rn && (!m_valid || ordy)));
        @(posedge clk);
        if (!rn) begin
            m_valid = 0; m_bin = 0; m_dir = 0; m_err = 0; m_cnt = 0;
            m_have_prev = 0; m_prev = 0;
        end else begin
            acc = v && (!m_valid || ordy);
            if (acc) begin
                cur = from_gray(g);
                m_dir = 0;
                m_err = 0;
                if (clr) begin
                    m_cnt = 0;
                end else if (m_have_prev) begin
                    diff = (cur - m_prev + 16) % 16;
                    if (diff == 1) m_dir = 1;
                    else if (diff == 15) m_dir = 2;
                    else if (diff != 0) begin
                        m_err = 1;
                        if (m_cnt < (1 << EW) - 1) m_cnt++;
                    end
                end
                m_have_prev = 1;
                m_prev  = cur;
                m_valid = 1;
                m_bin   = cur;
            end else begin
                if (ordy) m_valid = 0;
                if (clr) begin
                    m_have_prev = 0;
                    m_cnt = 0;
                end
            end
        end
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".out_valid"}, int'(bus.out_valid), int'(m_valid));
        chk({tag, ".err_count"}, int'(bus.err_count), m_cnt);
        if (m_valid) begin
            chk({tag, ".out_bin"}, int'(bus.out_bin), m_bin);
            chk({tag, ".out_dir"}, int'(bus.out_dir), m_dir);
            chk({tag, ".out_step_err"}, int'(bus.out_step_err), int'(m_err));
        end
    endtask

    function automatic vec_t mk(bit v, int b, bit ordy, bit clr, bit ev, int eb, int ed, bit ee, int ec);
        vec_t t;
        t.v = v; t.g = to_gray(b); t.ordy = ordy; t.clr = clr;
        t.e_valid = ev; t.e_bin = eb; t.e_dir = ed; t.e_err = ee; t.e_cnt = ec;
        return t;
    endfunction

    initial begin
        int nb;
        int r;
        bus.in_valid  = 1'b0;
        bus.in_gray   = 4'b0000;
        bus.out_ready = 1'b1;
        clear         = 1'b0;
        rst_n         = 1'b0;

        // Monotonic 0..4
        tbl.push_back(mk(1, 0, 1, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 1, 1, 1, 0, 0));
        tbl.push_back(mk(1, 2, 1, 0, 1, 2, 1, 0, 0));
        tbl.push_back(mk(1, 3, 1, 0, 1, 3, 1, 0, 0));
        tbl.push_back(mk(1, 4, 1, 0, 1, 4, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0));
        // Wrap up and down, history restarted by clear
        tbl.push_back(mk(1, 15, 1, 1, 1, 15, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 1, 0, 1, 0, 0));
        tbl.push_back(mk(1, 15, 1, 0, 1, 15, 2, 0, 0));
        // Illegal step then hold
        tbl.push_back(mk(1, 1, 1, 1, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 14, 1, 0, 1, 14, 0, 1, 1));
        tbl.push_back(mk(1, 14, 1, 0, 1, 14, 0, 0, 1));
        // Saturation at 3 with a 2-bit counter, then clear with a coincident code
        tbl.push_back(mk(1, 0, 1, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 8, 1, 0, 1, 8, 0, 1, 1));
        tbl.push_back(mk(1, 0, 1, 0, 1, 0, 0, 1, 2));
        tbl.push_back(mk(1, 8, 1, 0, 1, 8, 0, 1, 3));
        tbl.push_back(mk(1, 0, 1, 0, 1, 0, 0, 1, 3));
        tbl.push_back(mk(1, 8, 1, 0, 1, 8, 0, 1, 3));
        tbl.push_back(mk(1, 9, 1, 1, 1, 9, 0, 0, 0));
        tbl.push_back(mk(1, 5, 1, 0, 1, 5, 0, 1, 1));

        // Reset state
        drive(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
        chk("reset.in_ready_low", int'(bus.in_ready), 0);
        chk("reset.out_valid", int'(bus.out_valid), 0);
        chk("reset.out_bin", int'(bus.out_bin), 0);
        chk("reset.out_dir", int'(bus.out_dir), 0);
        chk("reset.out_step_err", int'(bus.out_step_err), 0);
        chk("reset.err_count", int'(bus.err_count), 0);

        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].g, tbl[i].ordy, tbl[i].clr, 1'b1);
            chk($sformatf("vec%0d.out_valid", i), int'(bus.out_valid), int'(tbl[i].e_valid));
            chk($sformatf("vec%0d.err_count", i), int'(bus.err_count), tbl[i].e_cnt);
            if (tbl[i].e_valid) begin
                chk($sformatf("vec%0d.out_bin", i), int'(bus.out_bin), tbl[i].e_bin);
                chk($sformatf("vec%0d.out_dir", i), int'(bus.out_dir), tbl[i].e_dir);
                chk($sformatf("vec%0d.out_step_err", i), int'(bus.out_step_err), int'(tbl[i].e_err));
            end
        end

        // Backpressure: beat for 5 must hold while code 6 waits
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, to_gray(6), 1'b0, 1'b0, 1'b1);
            chk("bp.in_ready_low", int'(bus.in_ready), 0);
            chk("bp.out_bin_held", int'(bus.out_bin), 5);
            chk("bp.out_dir_held", int'(bus.out_dir), 0);
            chk("bp.out_valid_held", int'(bus.out_valid), 1);
        end
        drive(1'b1, to_gray(6), 1'b1, 1'b0, 1'b1);
        chk("bp.next_bin", int'(bus.out_bin), 6);
        chk("bp.next_dir", int'(bus.out_dir), 1);
        check_model("bp");

        // Reset mid-stream with a pending beat and nonzero error count
        drive(1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
        drive(1'b1, to_gray(3), 1'b0, 1'b0, 1'b0);
        chk("rst.out_valid", int'(bus.out_valid), 0);
        chk("rst.err_count", int'(bus.err_count), 0);
        drive(1'b1, to_gray(3), 1'b1, 1'b0, 1'b1);
        chk("rst.first_valid", int'(bus.out_valid), 1);
        chk("rst.first_bin", int'(bus.out_bin), 3);
        chk("rst.first_dir", int'(bus.out_dir), 0);
        chk("rst.first_err", int'(bus.out_step_err), 0);

        // Random traffic biased toward legal steps
        for (int k = 0; k < 400; k++) begin
            r = $urandom_range(0, 9);
            if (r < 4) nb = (m_prev + 1) % 16;
            else if (r < 6) nb = (m_prev + 15) % 16;
            else if (r < 8) nb = m_prev;
            else nb = $urandom_range(0, 15);
            drive($urandom_range(0, 4) != 0, to_gray(nb), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 24) == 0, $urandom_range(0, 79) != 0);
            check_model($sformatf("rnd%0d", k));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
